gmii_rx_monitor: RTL and testbench
==================================

Name: gmii_rx_monitor

Overview:
Receive-side GMII frame monitor that sits on the PCS receive outputs (rxd, rx_dv, rx_er) and consumes what the PCS receive path delivers.
- Delimits frames on rx_dv and buffers up to MAX_OCTETS octets per frame.
- Computes per-frame length, 8-bit modular sum and error status.
- Keeps frame, error and false-carrier counters.
- Gives benches and on-chip checkers a synthesizable endpoint that compares transmitted txd sequences against received data.

Parameters:
- OCTET_WIDTH, 8, width of rxd and buffered octets.
- MAX_OCTETS, 32, buffer depth; a power of 2.
- ADDR_WIDTH, 5, log2(MAX_OCTETS).
- LEN_WIDTH, 8, width of frame_len; saturates at 2^LEN_WIDTH-1.
- CNT_WIDTH, 16, width of the statistics counters; each saturates at its maximum.

Ports:
- clk  input  1  rising-edge clock, same clock as the PCS receive path.
- mr_main_reset_n  input  1  asynchronous, active-low reset.
- rxd  input  OCTET_WIDTH  received octet.
- rx_dv  input  1  receive data valid.
- rx_er  input  1  receive error.
- rd_addr  input  ADDR_WIDTH  buffer read address.
- rd_data  output  OCTET_WIDTH  buffer octet at rd_addr, registered, 1-cycle latency.
- frame_valid  output  1  one-cycle pulse when a frame ends.
- frame_len  output  LEN_WIDTH  octet count of the last completed frame.
- frame_sum  output  OCTET_WIDTH  sum mod 256 of the frame's octets.
- frame_err  output  1  last frame had rx_er or buffer overflow.
- busy  output  1  high while in RECV.
- frame_count  output  CNT_WIDTH  completed frames.
- err_count  output  CNT_WIDTH  completed frames with frame_err=1.
- false_carrier_count  output  CNT_WIDTH  false-carrier cycles seen.

Behaviour:
- Reset: async assert of mr_main_reset_n=0 forces all outputs, counters, state and sums to 0 and state to IDLE. Buffer contents are not cleared; rd_data is 0 until the first read after reset.
- States: IDLE, RECV, REPORT.
- IDLE -> RECV on the first edge where rx_dv=1. That octet is written at address 0, and the running length and sum start with it.
- RECV, rx_dv=1:
  - Write rxd at address len while len<MAX_OCTETS.
  - len increments, saturating.
  - sum += rxd, mod 2^OCTET_WIDTH; octets past MAX_OCTETS still count toward len and sum.
  - rx_er=1 sets a sticky error. An octet beyond MAX_OCTETS sets a sticky overflow.
- RECV, rx_dv=0 -> REPORT. In that edge, frame_len, frame_sum and frame_err (error|overflow) are latched and frame_valid goes high for exactly the REPORT cycle. frame_count increments, and err_count increments if frame_err.
- REPORT, rx_dv=1 -> RECV, starting a new frame with its octet at address 0. This covers a back-to-back frame with a 1-cycle gap. REPORT, rx_dv=0 -> IDLE.
- Outside RECV, with rx_dv=0:
  - rx_er=1 with rxd=0x0E is a false carrier; false_carrier_count increments once per cycle.
  - rx_er=1 with rxd=0x0F (carrier extend) and all other rx_er-only cycles are ignored.
- frame_len/sum/err hold until the next frame end; they are not cleared at frame start.
- Reading: the buffer is valid from frame_valid until the next frame start. Reads during RECV return in-progress data; the bench must not check them.
- Reset mid-frame: the frame is discarded, no frame_valid, counters zero.
- A 0-octet frame is impossible, since RECV is entered with one octet.

Test Plan:
- Reset then 10 idle cycles (rx_dv=0, rx_er=0) -> all outputs 0, busy=0, no frame_valid.
- Frame 0x6B,0x37,0x87,0xAC, rx_er=0, then rx_dv=0 -> frame_valid is 1 cycle, frame_len=4, frame_sum=0xD5, frame_err=0, frame_count=1. Reading addr 0..3 returns 0x6B,0x37,0x87,0xAC at 1-cycle latency.
- Same 4-octet frame followed by 2 cycles of rx_dv=0, rx_er=1, rxd=0x0F -> frame_err=0, false_carrier_count=0, err_count=0.
- 3-octet frame with rx_er=1 on octet 2, then rx_dv=0, rx_er=1, rxd=0x0E for 1 cycle -> frame_len=3, frame_err=1, err_count=1, false_carrier_count=1.
- 40-octet frame of 0x01 -> frame_len=40, frame_sum=0x28, frame_err=1 (overflow), addr 0..31 read 0x01.
- Two 2-octet frames separated by one rx_dv=0 cycle -> two frame_valid pulses, frame_count=2, with the second frame's data at addr 0..1. Asserting reset mid-third-frame -> counters 0, no pulse.

Source files
------------

// File: rtl/gmii_rx_monitor_if.sv
// Bundle of GMII receive inputs, buffer read port and frame report/statistics outputs.
// The monitor is the slave side; whatever drives the PCS receive signals is the master.
interface gmii_rx_monitor_if #(
  parameter int OCTET_WIDTH = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int LEN_WIDTH   = 8,
  parameter int CNT_WIDTH   = 16
);
  logic [OCTET_WIDTH-1:0] rxd;
  logic                   rx_dv;
  logic                   rx_er;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [OCTET_WIDTH-1:0] rd_data;
  logic                   frame_valid;
  logic [LEN_WIDTH-1:0]   frame_len;
  logic [OCTET_WIDTH-1:0] frame_sum;
  logic                   frame_err;
  logic                   busy;
  logic [CNT_WIDTH-1:0]   frame_count;
  logic [CNT_WIDTH-1:0]   err_count;
  logic [CNT_WIDTH-1:0]   false_carrier_count;

  modport master (
    output rxd, rx_dv, rx_er, rd_addr,
    input  rd_data, frame_valid, frame_len, frame_sum, frame_err, busy,
           frame_count, err_count, false_carrier_count
  );

  modport slave (
    input  rxd, rx_dv, rx_er, rd_addr,
    output rd_data, frame_valid, frame_len, frame_sum, frame_err, busy,
           frame_count, err_count, false_carrier_count
  );
endinterface

// File: rtl/gmii_rx_monitor.sv
// GMII receive frame monitor: buffers each frame, reports length/sum/error on frame end,
// and keeps saturating frame, error and false-carrier counters.
module gmii_rx_monitor #(
  parameter int OCTET_WIDTH = 8,
  parameter int MAX_OCTETS  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int LEN_WIDTH   = 8,
  parameter int CNT_WIDTH   = 16
) (
  input logic              clk,
  input logic              mr_main_reset_n,
  gmii_rx_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RECV, REPORT} state_e;

  localparam logic [LEN_WIDTH-1:0]   LEN_MAX = {LEN_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [LEN_WIDTH-1:0]   BUF_LEN = LEN_WIDTH'(MAX_OCTETS);
  localparam logic [OCTET_WIDTH-1:0] FC_CODE = OCTET_WIDTH'(8'h0E);

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d, flen_q, flen_d;
  logic [OCTET_WIDTH-1:0] sum_q, sum_d, fsum_q, fsum_d;
  logic                   err_q, err_d, ovf_q, ovf_d, ferr_q, ferr_d;
  logic [CNT_WIDTH-1:0]   fcnt_q, fcnt_d, ecnt_q, ecnt_d, fccnt_q, fccnt_d;
  logic [OCTET_WIDTH-1:0] rd_data_q;
  logic                   we;
  logic [ADDR_WIDTH-1:0]  waddr;
  logic                   in_buf;

  logic [OCTET_WIDTH-1:0] mem [MAX_OCTETS];

  assign in_buf = (len_q < BUF_LEN);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    flen_d  = flen_q;
    fsum_d  = fsum_q;
    ferr_d  = ferr_q;
    fcnt_d  = fcnt_q;
    ecnt_d  = ecnt_q;
    fccnt_d = fccnt_q;
    we      = 1'b0;
    waddr   = len_q[ADDR_WIDTH-1:0];
    case (state_q)
      IDLE, REPORT: begin
        if (bus.rx_dv) begin
          // Frame start: this octet is octet 0, so running totals restart from it.
          state_d = RECV;
          we      = 1'b1;
          waddr   = '0;
          len_d   = LEN_WIDTH'(1);
          sum_d   = bus.rxd;
          err_d   = bus.rx_er;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
          if (bus.rx_er && bus.rxd == FC_CODE && fccnt_q != CNT_MAX)
            fccnt_d = fccnt_q + CNT_WIDTH'(1);
        end
      end
      RECV: begin
        if (bus.rx_dv) begin
          we    = in_buf;
          len_d = (len_q == LEN_MAX) ? len_q : len_q + LEN_WIDTH'(1);
          sum_d = sum_q + bus.rxd;
          err_d = err_q | bus.rx_er;
          ovf_d = ovf_q | ~in_buf;
        end else begin
          state_d = REPORT;
          flen_d  = len_q;
          fsum_d  = sum_q;
          ferr_d  = err_q | ovf_q;
          if (fcnt_q != CNT_MAX) fcnt_d = fcnt_q + CNT_WIDTH'(1);
          if ((err_q | ovf_q) && ecnt_q != CNT_MAX) ecnt_d = ecnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge mr_main_reset_n) begin
    if (!mr_main_reset_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      sum_q     <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      flen_q    <= '0;
      fsum_q    <= '0;
      ferr_q    <= 1'b0;
      fcnt_q    <= '0;
      ecnt_q    <= '0;
      fccnt_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      flen_q    <= flen_d;
      fsum_q    <= fsum_d;
      ferr_q    <= ferr_d;
      fcnt_q    <= fcnt_d;
      ecnt_q    <= ecnt_d;
      fccnt_q   <= fccnt_d;
      rd_data_q <= mem[bus.rd_addr];
    end
  end

  // Buffer RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= bus.rxd;
  end

  assign bus.rd_data             = rd_data_q;
  assign bus.frame_valid         = (state_q == REPORT);
  assign bus.frame_len           = flen_q;
  assign bus.frame_sum           = fsum_q;
  assign bus.frame_err           = ferr_q;
  assign bus.busy                = (state_q == RECV);
  assign bus.frame_count         = fcnt_q;
  assign bus.err_count           = ecnt_q;
  assign bus.false_carrier_count = fccnt_q;
endmodule

// File: tb/tb_gmii_rx_monitor.sv
// Directed plus randomized bench for gmii_rx_monitor against a frame-level reference model.
module tb_gmii_rx_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gmii_rx_monitor_if bus ();
  gmii_rx_monitor dut (.clk(clk), .mr_main_reset_n(rst_n), .bus(bus));

  int nchk = 0, npass = 0, nfail = 0;

  // Frame-level model: octets of the frame in progress, results of the last finished frame.
  logic [7:0] cur[$];
  bit         cur_err, prev_dv;
  bit         e_valid, e_busy, e_err;
  int         e_len, e_sum, e_fc, e_ec, e_fcc;
  logic [7:0] exp_buf [32];
  int         exp_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    cur_err = 0; prev_dv = 0;
    e_valid = 0; e_busy = 0; e_err = 0;
    e_len = 0; e_sum = 0; e_fc = 0; e_ec = 0; e_fcc = 0;
    exp_n = 0;
  endtask

  task automatic check_all();
    chk("frame_valid", 32'(bus.frame_valid), 32'(e_valid));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("frame_len", 32'(bus.frame_len), e_len);
    chk("frame_sum", 32'(bus.frame_sum), e_sum);
    chk("frame_err", 32'(bus.frame_err), 32'(e_err));
    chk("frame_count", 32'(bus.frame_count), e_fc);
    chk("err_count", 32'(bus.err_count), e_ec);
    chk("false_carrier_count", 32'(bus.false_carrier_count), e_fcc);
  endtask

  // One clock: model consumes the inputs present at the edge, then outputs are checked.
  task automatic tick();
    logic       dv = bus.rx_dv;
    logic       er = bus.rx_er;
    logic [7:0] d  = bus.rxd;
    int         n, s;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      e_valid = 0;
      if (dv) begin
        if (!prev_dv) begin cur.delete(); cur_err = 0; end
        cur.push_back(d);
        cur_err |= er;
      end else if (prev_dv) begin
        n = cur.size(); s = 0;
        foreach (cur[i]) s += cur[i];
        e_valid = 1;
        e_len   = (n > 255) ? 255 : n;
        e_sum   = s % 256;
        e_err   = cur_err || (n > 32);
        e_fc    = (e_fc == 65535) ? e_fc : e_fc + 1;
        if (e_err) e_ec = (e_ec == 65535) ? e_ec : e_ec + 1;
        exp_n = (n > 32) ? 32 : n;
        for (int i = 0; i < exp_n; i++) exp_buf[i] = cur[i];
      end else if (er && d == 8'h0E) begin
        e_fcc = (e_fcc == 65535) ? e_fcc : e_fcc + 1;
      end
      e_busy  = dv;
      prev_dv = dv;
    end
    #1;
    check_all();
  endtask

  task automatic octet(input logic [7:0] d, input logic er);
    bus.rx_dv = 1'b1; bus.rxd = d; bus.rx_er = er;
    tick();
  endtask

  task automatic idle(input logic [7:0] d, input logic er);
    bus.rx_dv = 1'b0; bus.rxd = d; bus.rx_er = er;
    tick();
  endtask

  task automatic rd(input int a, input logic [7:0] exp);
    bus.rd_addr = 5'(a);
    idle(8'h00, 1'b0);
    chk($sformatf("rd_data[%0d]", a), 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.rx_dv = 1'b0; bus.rx_er = 1'b0; bus.rxd = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] f4 [4];
    int         len, gap, sel;
    f4[0] = 8'h6B; f4[1] = 8'h37; f4[2] = 8'h87; f4[3] = 8'hAC;
    bus.rx_dv = 1'b0; bus.rx_er = 1'b0; bus.rxd = '0; bus.rd_addr = '0;
    model_reset();

    // Reset state, then quiet line.
    #1;
    check_all();
    chk("rd_data_reset", 32'(bus.rd_data), 0);
    do_reset();
    repeat (10) idle(8'h00, 1'b0);

    // Basic 4-octet frame.
    foreach (f4[i]) octet(f4[i], 1'b0);
    idle(8'h00, 1'b0);
    chk("t2_valid", 32'(bus.frame_valid), 1);
    chk("t2_len", 32'(bus.frame_len), 4);
    chk("t2_sum", 32'(bus.frame_sum), 32'h D5);
    chk("t2_err", 32'(bus.frame_err), 0);
    chk("t2_count", 32'(bus.frame_count), 1);
    foreach (f4[i]) rd(i, f4[i]);

    // Carrier extend after a frame is neither an error nor a false carrier.
    foreach (f4[i]) octet(f4[i], 1'b0);
    idle(8'h0F, 1'b1);
    idle(8'h0F, 1'b1);
    chk("t3_err", 32'(bus.frame_err), 0);
    chk("t3_fcc", 32'(bus.false_carrier_count), 0);
    chk("t3_ec", 32'(bus.err_count), 0);

    // rx_er inside a frame, then a false carrier outside it.
    octet(8'h11, 1'b0); octet(8'h22, 1'b1); octet(8'h33, 1'b0);
    idle(8'h00, 1'b0);
    idle(8'h0E, 1'b1);
    chk("t4_len", 32'(bus.frame_len), 3);
    chk("t4_err", 32'(bus.frame_err), 1);
    chk("t4_ec", 32'(bus.err_count), 1);
    chk("t4_fcc", 32'(bus.false_carrier_count), 1);

    // Overflow: 40 octets into a 32-deep buffer.
    repeat (40) octet(8'h01, 1'b0);
    idle(8'h00, 1'b0);
    chk("t5_len", 32'(bus.frame_len), 40);
    chk("t5_sum", 32'(bus.frame_sum), 32'h28);
    chk("t5_err", 32'(bus.frame_err), 1);
    for (int i = 0; i < 32; i++) rd(i, 8'h01);

    // Back-to-back frames with a 1-cycle gap, then reset mid-frame.
    do_reset();
    octet(8'hA1, 1'b0); octet(8'hA2, 1'b0);
    idle(8'h00, 1'b0);
    chk("t6_pulse1", 32'(bus.frame_valid), 1);
    octet(8'hB1, 1'b0); octet(8'hB2, 1'b0);
    idle(8'h00, 1'b0);
    chk("t6_pulse2", 32'(bus.frame_valid), 1);
    chk("t6_count", 32'(bus.frame_count), 2);
    rd(0, 8'hB1); rd(1, 8'hB2);
    octet(8'hC1, 1'b0); octet(8'hC2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_count", 32'(bus.frame_count), 0);
    chk("t6_rst_rd", 32'(bus.rd_data), 0);
    bus.rx_dv = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) idle(8'h00, 1'b0);
    chk("t6_no_pulse", 32'(bus.frame_valid), 0);

    // Randomized frames with random errors, gaps and idle-time rx_er codes.
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++)
        octet(8'($urandom), 1'(($urandom_range(0, 31) == 0)));
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        sel = $urandom_range(0, 3);
        idle((sel == 0) ? 8'h0E : (sel == 1) ? 8'h0F : 8'($urandom), 1'($urandom));
      end
      if ($urandom_range(0, 1) == 1)
        for (int k = 0; k < 3; k++) begin
          sel = $urandom_range(0, exp_n - 1);
          rd(sel, exp_buf[sel]);
        end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
